// File: rtl/regm_pkg.sv
// Shared defaults and address-width helper for the regm_sb register file.
package regm_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NRD   = 2;

    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regm_sb_if.sv
// Bus bundle for regm_sb: read ports, two write ports, issue port and busy count.
interface regm_sb_if
    import regm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = DEF_NRD
);
    localparam int AW = calc_aw(DEPTH);

    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 wr0_en;
    logic [AW-1:0]        wr0_addr;
    logic [WIDTH-1:0]     wr0_data;
    logic                 wr1_en;
    logic [AW-1:0]        wr1_addr;
    logic [WIDTH-1:0]     wr1_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic [AW:0]          busy_cnt;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr,
        output rd_data, rd_busy, busy_cnt
    );

endinterface

// File: rtl/regm_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears (set wins), registered popcount.
module regm_scoreboard
    import regm_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    parameter int  NRD   = DEF_NRD,
    localparam int AW    = calc_aw(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr0_ok,
    input  logic [AW-1:0]   wr0_addr,
    input  logic            wr1_ok,
    input  logic [AW-1:0]   wr1_addr,
    input  logic            iss_ok,
    input  logic [AW-1:0]   iss_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]  rd_busy,
    output logic [AW:0]     busy_cnt
);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;

    // Clears first so an issue in the same cycle leaves the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr0_ok) busy_d[wr0_addr] = 1'b0;
        if (wr1_ok) busy_d[wr1_addr] = 1'b0;
        if (iss_ok) busy_d[iss_addr] = 1'b1;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
        end
    end

    // A same-cycle writeback hides the old busy bit; a same-cycle issue shows up next cycle.
    always_comb begin
        logic [AW-1:0] a;
        a       = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*AW +: AW];
            rd_busy[k] = busy_q[a] && !((wr0_ok && (wr0_addr == a)) || (wr1_ok && (wr1_addr == a)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regm_sb.sv
// Multi-port register file with write bypass and an issue/writeback busy scoreboard.
module regm_sb
    import regm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NRD      = DEF_NRD,
    parameter int ZERO_REG = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    regm_sb_if.slave bus
);
    localparam int AW = calc_aw(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic                 wr0_ok, wr1_ok, iss_ok;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [AW:0]          busy_cnt;

    // Qualified enables: nothing acts during reset, and register 0 is inert when hardwired.
    always_comb begin
        wr0_ok = rst_n && bus.wr0_en && !((ZERO_REG != 0) && (bus.wr0_addr == '0));
        wr1_ok = rst_n && bus.wr1_en && !((ZERO_REG != 0) && (bus.wr1_addr == '0));
        iss_ok = rst_n && bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));
    end

    always_comb begin
        mem_d = mem_q;
        if (wr0_ok) mem_d[bus.wr0_addr] = bus.wr0_data;
        if (wr1_ok) mem_d[bus.wr1_addr] = bus.wr1_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] v;
        a       = '0;
        v       = '0;
        rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            a = bus.rd_addr[k*AW +: AW];
            v = mem_q[a];
            if (wr0_ok && (bus.wr0_addr == a)) v = bus.wr0_data;
            if (wr1_ok && (bus.wr1_addr == a)) v = bus.wr1_data;
            if (((ZERO_REG != 0) && (a == '0)) || !rst_n) v = '0;
            rd_data[k*WIDTH +: WIDTH] = v;
        end
    end

    regm_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_ok   (wr0_ok),
        .wr0_addr (bus.wr0_addr),
        .wr1_ok   (wr1_ok),
        .wr1_addr (bus.wr1_addr),
        .iss_ok   (iss_ok),
        .iss_addr (bus.iss_addr),
        .rd_addr  (bus.rd_addr),
        .rd_busy  (rd_busy),
        .busy_cnt (busy_cnt)
    );

    assign bus.rd_data  = rd_data;
    assign bus.rd_busy  = rd_busy;
    assign bus.busy_cnt = busy_cnt;

endmodule

// File: tb/tb_regm_sb.sv
// Vector-table bench for regm_sb with a queue of expected outputs plus reset corner sequences.
module tb_regm_sb;
    import regm_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 2;
    localparam int AW    = calc_aw(DEPTH);
    localparam int NVEC  = 17;

    typedef struct {
        logic             wr0_en;
        logic [AW-1:0]    wr0_addr;
        logic [WIDTH-1:0] wr0_data;
        logic             wr1_en;
        logic [AW-1:0]    wr1_addr;
        logic [WIDTH-1:0] wr1_data;
        logic             iss_en;
        logic [AW-1:0]    iss_addr;
        logic [AW-1:0]    ra0;
        logic [AW-1:0]    ra1;
        logic [WIDTH-1:0] e_rd0;
        logic [WIDTH-1:0] e_rd1;
        logic [1:0]       e_busy;
        logic [AW:0]      e_cnt;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] rd0;
        logic [WIDTH-1:0] rd1;
        logic [1:0]       busy;
        logic [AW:0]      cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [NVEC];
    exp_t exp_q [$];
    exp_t e;

    always #5 clk = ~clk;

    regm_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) bus ();

    regm_sb #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NRD      (NRD),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t mk(input logic w0e, input int w0a, input logic [31:0] w0d,
                                input logic w1e, input int w1a, input logic [31:0] w1d,
                                input logic ie, input int ia, input int r0, input int r1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eb, input int ec);
        vec_t v;
        v.wr0_en = w0e; v.wr0_addr = AW'(w0a); v.wr0_data = w0d;
        v.wr1_en = w1e; v.wr1_addr = AW'(w1a); v.wr1_data = w1d;
        v.iss_en = ie;  v.iss_addr = AW'(ia);
        v.ra0 = AW'(r0); v.ra1 = AW'(r1);
        v.e_rd0 = e0; v.e_rd1 = e1; v.e_busy = eb; v.e_cnt = (AW+1)'(ec);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive_idle();
        bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0;
    endtask

    task automatic set_rd(input int r0, input int r1);
        bus.rd_addr = {AW'(r1), AW'(r0)};
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.wr0_en = v.wr0_en; bus.wr0_addr = v.wr0_addr; bus.wr0_data = v.wr0_data;
        bus.wr1_en = v.wr1_en; bus.wr1_addr = v.wr1_addr; bus.wr1_data = v.wr1_data;
        bus.iss_en = v.iss_en; bus.iss_addr = v.iss_addr;
        bus.rd_addr = {v.ra1, v.ra0};
        exp_q.push_back('{v.e_rd0, v.e_rd1, v.e_busy, v.e_cnt});
    endtask

    initial begin
        //                w0e w0a w0d           w1e w1a w1d    ie ia r0 r1  e_rd0         e_rd1         busy   cnt
        vecs[0]  = mk(1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1'b0, 0, 0, 1, 32'h0,        32'h0,        2'b00, 0);
        vecs[1]  = mk(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0,  1'b0, 0, 0, 5, 32'h0,        32'hDEADBEEF, 2'b00, 0);
        vecs[2]  = mk(1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1'b0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
        vecs[3]  = mk(1'b1, 7, 32'h1,        1'b1, 7, 32'h2,  1'b0, 0, 7, 5, 32'h2,        32'hDEADBEEF, 2'b00, 0);
        vecs[4]  = mk(1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1'b0, 0, 7, 6, 32'h2,        32'h0,        2'b00, 0);
        vecs[5]  = mk(1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1'b1, 3, 3, 6, 32'h0,        32'h0,        2'b00, 0);
        vecs[6]  = mk(1'b0, 0, 32'h0,        1'b1, 3, 32'h33, 1'b1, 3, 3, 7, 32'h33,       32'h2,        2'b00, 1);
        vecs[7]  = mk(1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1'b0, 0, 3, 3, 32'h33,       32'h33,       2'b11, 1);
        vecs[8]  = mk(1'b1, 0, 32'hFFFF,     1'b0, 0, 32'h0,  1'b1, 0, 0, 3, 32'h0,        32'h33,       2'b10, 1);
        vecs[9]  = mk(1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1'b0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 1);
        vecs[10] = mk(1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1'b1, 3, 3, 7, 32'h33,       32'h2,        2'b01, 1);
        vecs[11] = mk(1'b1, 3, 32'h44,       1'b0, 0, 32'h0,  1'b0, 0, 3, 5, 32'h44,       32'hDEADBEEF, 2'b00, 1);
        vecs[12] = mk(1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1'b0, 0, 3, 7, 32'h44,       32'h2,        2'b00, 0);
        vecs[13] = mk(1'b1, 9, 32'hA,        1'b1, 10, 32'hB, 1'b0, 0, 9, 10, 32'hA,       32'hB,        2'b00, 0);
        vecs[14] = mk(1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1'b1, 9, 9, 10, 32'hA,       32'hB,        2'b00, 0);
        vecs[15] = mk(1'b1, 9, 32'hC,        1'b0, 0, 32'h0,  1'b1, 10, 9, 10, 32'hC,      32'hB,        2'b00, 1);
        vecs[16] = mk(1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1'b0, 0, 9, 10, 32'hC,       32'hB,        2'b10, 1);

        drive_idle();
        set_rd(0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            set_rd(a, DEPTH - 1 - a);
            #1;
            checkOutput("reset_rd_data", 64'(bus.rd_data), 64'(0));
            checkOutput("reset_rd_busy", 64'(bus.rd_busy), 64'(0));
        end
        checkOutput("reset_busy_cnt", 64'(bus.busy_cnt), 64'(0));

        @(posedge clk);
        #1;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checkOutput($sformatf("v%0d_rd0", i), 64'(bus.rd_data[WIDTH-1:0]), 64'(e.rd0));
            checkOutput($sformatf("v%0d_rd1", i), 64'(bus.rd_data[2*WIDTH-1:WIDTH]), 64'(e.rd1));
            checkOutput($sformatf("v%0d_busy", i), 64'(bus.rd_busy), 64'(e.busy));
            checkOutput($sformatf("v%0d_cnt", i), 64'(bus.busy_cnt), 64'(e.cnt));
            @(posedge clk);
            #1;
        end
        drive_idle();

        // Four more issues on top of register 10, which is still busy.
        for (int r = 12; r < 16; r++) begin
            bus.iss_en   = 1'b1;
            bus.iss_addr = AW'(r);
            @(posedge clk);
            #1;
        end
        drive_idle();
        set_rd(12, 13);
        #1;
        checkOutput("four_issue_cnt", 64'(bus.busy_cnt), 64'(5));
        checkOutput("four_issue_busy", 64'(bus.rd_busy), 64'(2'b11));

        set_rd(5, 7);
        #1;
        checkOutput("pre_rst_rd0", 64'(bus.rd_data[WIDTH-1:0]), 64'(32'hDEADBEEF));
        checkOutput("pre_rst_rd1", 64'(bus.rd_data[2*WIDTH-1:WIDTH]), 64'(32'h2));
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_cnt", 64'(bus.busy_cnt), 64'(0));
        checkOutput("mid_rst_rd0", 64'(bus.rd_data[WIDTH-1:0]), 64'(0));
        checkOutput("mid_rst_rd1", 64'(bus.rd_data[2*WIDTH-1:WIDTH]), 64'(0));
        set_rd(12, 13);
        #1;
        checkOutput("mid_rst_busy", 64'(bus.rd_busy), 64'(0));

        bus.wr0_en = 1'b1; bus.wr0_addr = AW'(5); bus.wr0_data = 32'h1234;
        bus.iss_en = 1'b1; bus.iss_addr = AW'(6);
        set_rd(5, 6);
        #1;
        checkOutput("rst_bypass_gated", 64'(bus.rd_data[WIDTH-1:0]), 64'(0));
        @(posedge clk);
        #1;
        checkOutput("rst_write_ignored", 64'(bus.rd_data[WIDTH-1:0]), 64'(0));
        drive_idle();
        #2 rst_n = 1'b1;
        #1;
        checkOutput("post_rst_rd0", 64'(bus.rd_data[WIDTH-1:0]), 64'(0));
        checkOutput("post_rst_busy", 64'(bus.rd_busy), 64'(0));
        checkOutput("post_rst_cnt", 64'(bus.busy_cnt), 64'(0));

        bus.wr0_en = 1'b1; bus.wr0_addr = AW'(5); bus.wr0_data = 32'h55;
        bus.iss_en = 1'b1; bus.iss_addr = AW'(6);
        @(posedge clk);
        #1;
        drive_idle();
        #1;
        checkOutput("first_edge_wr", 64'(bus.rd_data[WIDTH-1:0]), 64'(32'h55));
        checkOutput("first_edge_busy", 64'(bus.rd_busy), 64'(2'b10));
        checkOutput("first_edge_cnt", 64'(bus.busy_cnt), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regm_sb.md
REGM_SB -- requirements
Module: regm_sb

Interface
REQ-001 Parameter WIDTH, default 32, data width of every register.
REQ-002 Parameter DEPTH, default 32, number of registers; power of two, at least 2; AW = log2(DEPTH).
REQ-003 Parameter NRD, default 2, number of independent read ports, from 1 to 4.
REQ-004 Parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-007 Port rd_addr, input, NRD*AW bits: read addresses; port k occupies bits [k*AW +: AW].
REQ-008 Port rd_data, output, NRD*WIDTH bits: read data; port k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port rd_busy, output, NRD bits: the register on read port k has an outstanding producer.
REQ-010 Ports wr0_en (1), wr0_addr (AW), wr0_data (WIDTH), inputs: write/writeback port 0.
REQ-011 Ports wr1_en (1), wr1_addr (AW), wr1_data (WIDTH), inputs: write/writeback port 1, higher priority.
REQ-012 Ports iss_en (1), iss_addr (AW), inputs: issue; marks the destination register busy.
REQ-013 Port busy_cnt, output, AW+1 bits, registered: number of registers currently busy.

Function
REQ-014 Reads shall be combinational: rd_data[k] = mem[rd_addr[k]], subject to REQ-015 and REQ-016.
REQ-015 Bypass: a read address matching an enabled write address shall return that write data in the same cycle; when both write ports match, wr1 data is returned.
REQ-016 With ZERO_REG=1, reads of address 0 shall return 0, writes to address 0 shall be ignored, and register 0 shall never become busy or bypass.
REQ-017 On a rising edge, an enabled write shall store its data; when wr0 and wr1 target the same address, the register shall take wr1_data.
REQ-018 Scoreboard: one busy bit per register; iss_en shall set busy[iss_addr] on the edge.
REQ-019 An enabled write on either port shall clear busy[addr] on the edge.
REQ-020 When set and clear hit the same address in the same cycle, set wins: the register ends busy with the new data stored.
REQ-021 rd_busy[k] = busy[rd_addr[k]] AND NOT (a write to rd_addr[k] in the same cycle); when an issue also targets that address in that cycle, the issue does not affect rd_busy until the next cycle.
REQ-022 An issue to an already-busy register shall leave it busy with no error, and busy_cnt shall not double-count it.
REQ-023 busy_cnt shall equal the population count of the busy bits after each edge, updated with the busy bits; it is never negative and never exceeds DEPTH-ZERO_REG.

Reset
REQ-024 Asserting rst_n low shall immediately clear all registers to 0, all busy bits to 0 and busy_cnt to 0, regardless of clk.
REQ-025 While rst_n is low, writes and issues shall be ignored, rd_data shall read 0 and rd_busy shall be 0.
REQ-026 After rst_n deasserts, the first edge shall accept writes and issues normally.
REQ-027 A reset in mid-operation shall discard all pending busy state with no partial update.

Structure
REQ-028 The shared package regm_pkg shall hold the default WIDTH/DEPTH/NRD constants and the function that derives AW.
REQ-029 The scoreboard (busy bits, set/clear priority and busy_cnt) shall be a sub-module named regm_scoreboard; storage and bypass stay at top level.

Verification
REQ-030 Reset then read all addresses -> rd_data=0 and rd_busy=0 on every port, busy_cnt=0.
REQ-031 wr0 to address 5 with 0xDEADBEEF while port 1 reads 5 -> same cycle rd_data[1]=0xDEADBEEF; next cycle mem[5] holds it.
REQ-032 wr0 and wr1 both to address 7 (0x1, 0x2) with a read of 7 -> bypass returns 0x2 and address 7 holds 0x2 afterwards.
REQ-033 Issue to 3, then next cycle wr1 to 3 while iss_en targets 3 -> busy_cnt 1 -> 1, rd_busy for 3 is 0 during the write cycle and 1 in the following cycle.
REQ-034 Write 0xFFFF to address 0 and issue to address 0 -> reading 0 returns 0, rd_busy=0, busy_cnt unchanged.
REQ-035 Issue to 4 registers, then assert rst_n mid-cycle -> busy_cnt is 0 and contents are 0 immediately, with no clock edge.
